// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        BYTES,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned COUNT_W        = 8 * HDR_BYTES;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_data, mem_wren
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// Big-endian byte-to-word packer: shift register of the first three bytes plus byte index.
module word_packer
    import imem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              last_byte
);
    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

    // Only the leading bytes are stored; the final byte is merged straight from the input.
    logic [DATA_W-9:0] sreg;
    logic [IDX_W-1:0]  idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            idx  <= '0;
        end else if (shift) begin
            sreg <= {sreg[DATA_W-17:0], byte_in};
            idx  <= idx + IDX_W'(1);
        end
    end

    assign word      = {sreg, byte_in};
    assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: header word count, packed payload, CPU hold until loaded.
// Optional trailing mod-256 checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    imem_loader_if.slave    bus,
    output logic            cpu_hold,
    output logic            done,
    output logic            error
);
    localparam logic [COUNT_W:0] MAX_WORDS = {{COUNT_W{1'b0}}, 1'b1} << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CSUM;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t              state, state_next;
    logic [COUNT_W-1:0]  n_words, n_written, hdr_count;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W-1:0]   packed_word;
    logic                last_byte, last_word, xfer, shift, ready;

    assign xfer      = bus.in_valid & ready;
    assign shift     = (state == BYTES) & xfer;
    assign hdr_count = {n_words[COUNT_W-1:8], bus.in_data};
    assign last_word = ((n_written + COUNT_W'(1)) == n_words);

    word_packer #(.DATA_W(DATA_W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .shift     (shift),
        .byte_in   (bus.in_data),
        .word      (packed_word),
        .last_byte (last_byte)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      csum <= '0;
        else if (shift) csum <= csum + bus.in_data;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HDR_HI;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        unique case (state)
            HDR_HI: begin
                ready = 1'b1;
                if (xfer) state_next = HDR_LO;
            end
            HDR_LO: begin
                ready = 1'b1;
                if (xfer) begin
                    if (hdr_count == '0)                  state_next = END_STATE;
                    else if ({1'b0, hdr_count} > MAX_WORDS) state_next = ERR;
                    else                                  state_next = BYTES;
                end
            end
            BYTES: begin
                ready = 1'b1;
                if (xfer && last_byte) state_next = WRITE;
            end
            WRITE: state_next = last_word ? END_STATE : BYTES;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                ready = 1'b1;
                if (xfer) state_next = (bus.in_data == csum) ? DONE : ERR;
            end
`endif
            DONE:    state_next = DONE;
            ERR:     state_next = ERR;
            default: state_next = ERR;
        endcase
    end

    // The address is not advanced after the final word so it never wraps past the last entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_words   <= '0;
            n_written <= '0;
            addr      <= '0;
            wdata     <= '0;
        end else begin
            if (state == HDR_HI && xfer) n_words[COUNT_W-1:8] <= bus.in_data;
            if (state == HDR_LO && xfer) n_words[7:0]         <= bus.in_data;
            if (shift && last_byte)      wdata                <= packed_word;
            if (state == WRITE) begin
                n_written <= n_written + COUNT_W'(1);
                if (!last_word) addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.mem_addr = addr;
    assign bus.mem_data = wdata;
    assign bus.mem_wren = (state == WRITE);
    assign cpu_hold     = (state != DONE);
    assign done         = (state == DONE);
    assign error        = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader; checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;
    localparam int unsigned ADDR_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_hold, done, error;

    wr_t         exp_q[$];
    logic [7:0]  stim[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned wr_count = 0;
    bit          csum_bad = 1'b0;

    imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset && bus.mem_wren) begin
            wr_count++;
            check("ready_in_write", 32'(bus.in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", bus.mem_data, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int unsigned guard = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0 && guard < 8) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                @(posedge clk); #1;
                guard++;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) check("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_stim(input bit rnd);
        logic [15:0] n;
        logic [31:0] w;
        int unsigned p;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] sum = '0;
`endif
        n = {stim[0], stim[1]};
        w = '0;
        for (int i = 0; i < stim.size(); i++) begin
            if (i >= 2) begin
                p = i - 2;
                w = {w[23:0], stim[i]};
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum = sum + stim[i];
`endif
                if (p % 4 == 3 && n != 0 && n <= 16'd256)
                    exp_q.push_back('{addr: ADDR_W'(p / 4), data: w});
            end
            send_byte(stim[i], rnd);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (n <= 16'd256) send_byte(sum ^ {7'b0, csum_bad}, rnd);
`endif
    endtask

    task automatic wait_end();
        int unsigned g = 0;
        while (!(done || error) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!(done || error)) check("end_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_data", bus.mem_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        wr_count = 0;
        csum_bad = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // two-word image
        do_reset();
        stim = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h3C};
        run_stim(1'b0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        check("t1_wren2", 32'(bus.mem_wren), 32'd1);
        check("t1_done_at_wr", 32'(done), 32'd0);
        check("t1_hold_at_wr", 32'(cpu_hold), 32'd1);
        @(negedge clk);
`else
        wait_end();
`endif
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_writes", wr_count, 32'd2);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // empty image, then ignored traffic in DONE
        do_reset();
        stim = {8'h00, 8'h00};
        run_stim(1'b0);
        @(negedge clk);
        check("t2_done", 32'(done), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd0);
        check("t2_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t2_done_hold", 32'(done), 32'd1);
        check("t2_writes", wr_count, 32'd0);

        // oversize image rejected
        do_reset();
        stim = {8'h01, 8'h01};
        run_stim(1'b0);
        repeat (3) @(negedge clk);
        check("t3_error", 32'(error), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        check("t3_ready", 32'(bus.in_ready), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        check("t3_writes", wr_count, 32'd0);

        // full-depth image fills every address
        do_reset();
        stim = {8'h01, 8'h00};
        for (int i = 0; i < 1024; i++) stim.push_back(8'($urandom));
        run_stim(1'b0);
        wait_end();
        check("t4_done", 32'(done), 32'd1);
        check("t4_error", 32'(error), 32'd0);
        check("t4_writes", wr_count, 32'd256);
        check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // random valid gaps
        do_reset();
        stim = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        run_stim(1'b1);
        wait_end();
        check("t5_done", 32'(done), 32'd1);
        check("t5_writes", wr_count, 32'd1);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset mid-payload, then a clean reload
        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        do_reset();
        stim = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_stim(1'b0);
        wait_end();
        check("t6_done", 32'(done), 32'd1);
        check("t6_writes", wr_count, 32'd1);
        check("t6_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // matching and corrupted trailing sum
        do_reset();
        stim = {8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        run_stim(1'b0);
        wait_end();
        check("t7_done", 32'(done), 32'd1);
        check("t7_error", 32'(error), 32'd0);
        do_reset();
        csum_bad = 1'b1;
        run_stim(1'b0);
        wait_end();
        check("t8_error", 32'(error), 32'd1);
        check("t8_hold", 32'(cpu_hold), 32'd1);
        check("t8_writes", wr_count, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
